// File: rtl/plic_pkg.sv
// PLIC shared types and sizing for the per-source gateway.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: gw_state_e gateway FSM encoding, PLIC_IRQ_NUM / PLIC_IRQ_WIDTH sizing.
package plic_pkg;

  localparam int PLIC_IRQ_NUM = 8;
  localparam int PLIC_IRQ_WIDTH = 4;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PEND    = 2'd1,
    GW_CLAIMED = 2'd2
  } gw_state_e;

endpackage

// File: rtl/plic_gateway_if.sv
// Gateway bundle: raw interrupt lines, claim/complete strobes, pending/busy vectors.
// Latency: n/a (wires only).
// Backpressure: none; strobes are single-cycle and always accepted or ignored.
// Modports: master drives lines/strobes and observes ip_o/busy_o; slave is the gateway.
interface plic_gateway_if;
  import plic_pkg::*;

  logic [PLIC_IRQ_NUM-1:0]   irq_i;
  logic [PLIC_IRQ_NUM-1:0]   edge_i;
  logic                      claim_i;
  logic [PLIC_IRQ_WIDTH-1:0] claim_id_i;
  logic                      complete_i;
  logic [PLIC_IRQ_WIDTH-1:0] complete_id_i;
  logic [PLIC_IRQ_NUM-1:0]   ip_o;
  logic [PLIC_IRQ_NUM-1:0]   busy_o;

  modport master (
    output irq_i, edge_i, claim_i, claim_id_i, complete_i, complete_id_i,
    input  ip_o, busy_o
  );

  modport slave (
    input  irq_i, edge_i, claim_i, claim_id_i, complete_i, complete_id_i,
    output ip_o, busy_o
  );
endinterface

// File: rtl/plic_gw_cell.sv
// One gateway source: synchroniser, rising-edge detector, saturating edge counter, FSM.
// Latency: line->ip is SYNC_STAGES+1 (level) or SYNC_STAGES+2 (edge); strobe->ip/busy 1 cycle.
// Backpressure: none; edges beyond MAX_PEND outstanding are dropped.
// Ports: clk/rst, irq (raw line), edge_mode, decoded claim_hit/complete_hit, ip/busy state flags.
module plic_gw_cell
  import plic_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_PEND    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic edge_mode,
  input  logic claim_hit,
  input  logic complete_hit,
  output logic ip,
  output logic busy
);
  localparam int CNT_W = $clog2(MAX_PEND + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PEND);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   line;
  logic                   edge_det;
  logic [CNT_W-1:0]       cnt_q;
  logic                   take_edge;
  logic                   cnt_inc;
  gw_state_e              state_q, state_d;

  assign line     = sync_q[SYNC_STAGES-1];
  assign edge_det = line & ~prev_q;

  always_comb begin
    state_d   = state_q;
    take_edge = 1'b0;
    case (state_q)
      GW_IDLE: begin
        if (edge_mode) begin
          if (cnt_q != '0) begin
            state_d   = GW_PEND;
            take_edge = 1'b1;
          end
        end else if (line) begin
          state_d = GW_PEND;
        end
      end
      GW_PEND:    if (claim_hit)    state_d = GW_CLAIMED;
      GW_CLAIMED: if (complete_hit) state_d = GW_IDLE;
      default:    state_d = GW_IDLE;
    endcase
    // At saturation an edge still fits if a count is consumed the same cycle.
    cnt_inc = edge_det && ((cnt_q != CNT_MAX) || take_edge);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= GW_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
      prev_q <= line;
      // Level mode keeps the counter parked at zero so a switch to edge mode starts clean.
      if (!edge_mode) cnt_q <= '0;
      else            cnt_q <= cnt_q + CNT_W'(cnt_inc) - CNT_W'(take_edge);
    end
  end

  assign ip   = (state_q == GW_PEND);
  assign busy = (state_q == GW_CLAIMED);
endmodule

// File: rtl/plic_gateway.sv
// PLIC interrupt gateway: per-source pending/in-service tracking ahead of the priority tree.
// Latency: level irq->ip SYNC_STAGES+1, edge irq->ip SYNC_STAGES+2, claim/complete->ip/busy 1.
// Backpressure: none; illegal or out-of-range strobes are ignored.
// Ports: clk_i, rst_i (sync, active-high), gw (slave modport: lines, strobes, ip_o, busy_o).
module plic_gateway
  import plic_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_PEND    = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  plic_gateway_if.slave  gw
);
  // ID 0 is reserved: no cell, outputs tied low, its input bits deliberately dropped.
  logic unused_id0;
  assign unused_id0   = gw.irq_i[0] ^ gw.edge_i[0];
  assign gw.ip_o[0]   = 1'b0;
  assign gw.busy_o[0] = 1'b0;

  // IDs 0 and >= PLIC_IRQ_NUM never match any cell, so those strobes fall through.
  for (genvar i = 1; i < PLIC_IRQ_NUM; i++) begin : g_src
    logic claim_hit;
    logic complete_hit;

    assign claim_hit    = gw.claim_i    && (gw.claim_id_i    == PLIC_IRQ_WIDTH'(i));
    assign complete_hit = gw.complete_i && (gw.complete_id_i == PLIC_IRQ_WIDTH'(i));

    plic_gw_cell #(
      .SYNC_STAGES (SYNC_STAGES),
      .MAX_PEND    (MAX_PEND)
    ) u_cell (
      .clk          (clk_i),
      .rst          (rst_i),
      .irq          (gw.irq_i[i]),
      .edge_mode    (gw.edge_i[i]),
      .claim_hit    (claim_hit),
      .complete_hit (complete_hit),
      .ip           (gw.ip_o[i]),
      .busy         (gw.busy_o[i])
    );
  end
endmodule
